// File: rtl/cajero_automatico.sv
// ATM card-session controller: card acceptance, 4-digit PIN check with lockout, one deposit or
// withdrawal per session. Define CAJERO_LIMITE_RETIRO_EN to reject withdrawals above MAX_RETIRO.
module cajero_automatico #(
  parameter int unsigned MAX_INTENTOS = 3,
  parameter logic [31:0] MAX_RETIRO   = 32'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TARJETA_RECIBIDA,
  input  logic        TIPO_TRANS,
  input  logic        DIGITO_STB,
  input  logic [3:0]  DIGITO,
  input  logic [15:0] PIN,
  input  logic        MONTO_STB,
  input  logic [31:0] MONTO,
  input  logic [63:0] BALANCE_INICIAL,
  output logic [63:0] BALANCE,
  output logic        BALANCE_ACTUALIZADO,
  output logic        ENTREGAR_DINERO,
  output logic        FONDOS_INSUFICIENTES,
  output logic        PIN_INCORRECTO,
  output logic        ADVERTENCIA,
  output logic        BLOQUEO
);

  localparam int unsigned AW = $clog2(MAX_INTENTOS + 1);
  localparam logic [AW-1:0] IntentosLim   = AW'(MAX_INTENTOS);
  localparam logic [AW-1:0] IntentosAviso = AW'(MAX_INTENTOS - 1);

  typedef enum logic [2:0] {
    StEspera,
    StPinCaptura,
    StVerifica,
    StEsperaMonto,
    StTransaccion,
    StBloqueado
  } estado_e;

  estado_e        estado_q;
  logic           tipo_q;
  logic [15:0]    pin_q;
  logic [1:0]     indice_q;
  logic [AW-1:0]  intentos_q;
  logic [31:0]    monto_q;

  logic [AW-1:0]  intentos_sig;
  logic [64:0]    suma;
  logic           excede_cap;
  logic           retiro_rechazado;

  always_comb begin
    intentos_sig = intentos_q + AW'(1);
    suma         = {1'b0, BALANCE} + {33'd0, monto_q};
    excede_cap   = monto_q > MAX_RETIRO;
`ifdef CAJERO_LIMITE_RETIRO_EN
    retiro_rechazado = ({32'd0, monto_q} > BALANCE) | excede_cap;
`else
    // Cap compiled out: the cap comparison is computed but never affects the decision.
    retiro_rechazado = ({32'd0, monto_q} > BALANCE) | (excede_cap & 1'b0);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q             <= StEspera;
      tipo_q               <= 1'b0;
      pin_q                <= '0;
      indice_q             <= '0;
      intentos_q           <= '0;
      monto_q              <= '0;
      BALANCE              <= '0;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= 1'b0;
      BLOQUEO              <= 1'b0;
    end else begin
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= 1'b0;
      unique case (estado_q)
        StEspera: begin
          if (TARJETA_RECIBIDA) begin
            tipo_q     <= TIPO_TRANS;
            BALANCE    <= BALANCE_INICIAL;
            intentos_q <= '0;
            indice_q   <= '0;
            estado_q   <= StPinCaptura;
          end
        end
        StPinCaptura: begin
          if (DIGITO_STB) begin
            pin_q    <= {pin_q[11:0], DIGITO};
            indice_q <= indice_q + 2'd1;
            if (indice_q == 2'd3) estado_q <= StVerifica;
          end
        end
        StVerifica: begin
          indice_q <= '0;
          if (pin_q == PIN) begin
            intentos_q <= '0;
            estado_q   <= StEsperaMonto;
          end else begin
            intentos_q <= intentos_sig;
            if (intentos_sig == IntentosLim) begin
              // Final failure locks the card without a wrong-PIN pulse.
              BLOQUEO  <= 1'b1;
              estado_q <= StBloqueado;
            end else begin
              PIN_INCORRECTO <= 1'b1;
              ADVERTENCIA    <= (intentos_sig == IntentosAviso);
              estado_q       <= StPinCaptura;
            end
          end
        end
        StEsperaMonto: begin
          if (MONTO_STB) begin
            monto_q  <= MONTO;
            estado_q <= StTransaccion;
          end
        end
        StTransaccion: begin
          estado_q <= StEspera;
          if (!tipo_q) begin
            BALANCE             <= suma[64] ? '1 : suma[63:0];
            BALANCE_ACTUALIZADO <= 1'b1;
          end else if (retiro_rechazado) begin
            FONDOS_INSUFICIENTES <= 1'b1;
          end else begin
            BALANCE             <= BALANCE - {32'd0, monto_q};
            ENTREGAR_DINERO     <= 1'b1;
            BALANCE_ACTUALIZADO <= 1'b1;
          end
        end
        StBloqueado: ;
        default: estado_q <= StEspera;
      endcase
    end
  end

endmodule

// File: tb/tb_cajero_automatico.sv
// Self-checking bench for cajero_automatico: directed scenarios plus randomized sessions
// checked against a session-level account model.
module tb_cajero_automatico;

  localparam logic [31:0] MAX_RETIRO = 32'd5000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        TARJETA_RECIBIDA = 1'b0;
  logic        TIPO_TRANS = 1'b0;
  logic        DIGITO_STB = 1'b0;
  logic [3:0]  DIGITO = '0;
  logic [15:0] PIN = 16'h1194;
  logic        MONTO_STB = 1'b0;
  logic [31:0] MONTO = '0;
  logic [63:0] BALANCE_INICIAL = '0;
  logic [63:0] BALANCE;
  logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES;
  logic        PIN_INCORRECTO, ADVERTENCIA, BLOQUEO;

  always #5 clk = ~clk;

  cajero_automatico #(
    .MAX_INTENTOS(3),
    .MAX_RETIRO  (MAX_RETIRO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .TARJETA_RECIBIDA    (TARJETA_RECIBIDA),
    .TIPO_TRANS          (TIPO_TRANS),
    .DIGITO_STB          (DIGITO_STB),
    .DIGITO              (DIGITO),
    .PIN                 (PIN),
    .MONTO_STB           (MONTO_STB),
    .MONTO               (MONTO),
    .BALANCE_INICIAL     (BALANCE_INICIAL),
    .BALANCE             (BALANCE),
    .BALANCE_ACTUALIZADO (BALANCE_ACTUALIZADO),
    .ENTREGAR_DINERO     (ENTREGAR_DINERO),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES),
    .PIN_INCORRECTO      (PIN_INCORRECTO),
    .ADVERTENCIA         (ADVERTENCIA),
    .BLOQUEO             (BLOQUEO)
  );

  int checks = 0;
  int errors = 0;

  // Pulse counters sampled on the falling edge.
  int n_act, n_ent, n_fon, n_pin, n_adv;
  int n_doble = 0, n_adv_solo = 0;
  logic p_act = 0, p_ent = 0, p_fon = 0, p_pin = 0, p_adv = 0;

  always @(negedge clk) begin
    if (BALANCE_ACTUALIZADO) n_act++;
    if (ENTREGAR_DINERO) n_ent++;
    if (FONDOS_INSUFICIENTES) n_fon++;
    if (PIN_INCORRECTO) n_pin++;
    if (ADVERTENCIA) n_adv++;
    if (ADVERTENCIA && !PIN_INCORRECTO) n_adv_solo++;
    if ((BALANCE_ACTUALIZADO && p_act) || (ENTREGAR_DINERO && p_ent) ||
        (FONDOS_INSUFICIENTES && p_fon) || (PIN_INCORRECTO && p_pin) || (ADVERTENCIA && p_adv))
      n_doble++;
    p_act = BALANCE_ACTUALIZADO;
    p_ent = ENTREGAR_DINERO;
    p_fon = FONDOS_INSUFICIENTES;
    p_pin = PIN_INCORRECTO;
    p_adv = ADVERTENCIA;
  end

  function automatic logic [39:0] cnt_vec();
    return {8'(n_act), 8'(n_ent), 8'(n_fon), 8'(n_pin), 8'(n_adv)};
  endfunction

  // Account model: resulting balance and the expected {act,ent,fon,pin,adv} pulse counts.
  function automatic logic [63:0] ref_tx(input bit tipo, input logic [63:0] bal,
                                         input logic [31:0] m, output logic [39:0] pulsos);
    logic [64:0] s;
    bit rej;
    if (!tipo) begin
      s = {1'b0, bal} + 65'(m);
      pulsos = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
      return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
    end
    rej = 64'(m) > bal;
`ifdef CAJERO_LIMITE_RETIRO_EN
    if (m > MAX_RETIRO) rej = 1;
`endif
    if (rej) begin
      pulsos = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
      return bal;
    end
    pulsos = {8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
    return bal - 64'(m);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_act = 0; n_ent = 0; n_fon = 0; n_pin = 0; n_adv = 0;
  endtask

  task automatic insert_card(input logic tipo, input logic [63:0] bal);
    TARJETA_RECIBIDA = 1; TIPO_TRANS = tipo; BALANCE_INICIAL = bal;
    tick(1);
    TARJETA_RECIBIDA = 0;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    DIGITO_STB = 1; DIGITO = d;
    tick(1);
    DIGITO_STB = 0;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) enter_digit(p[i*4 +: 4]);
    tick(3);
  endtask

  task automatic enter_amount(input logic [31:0] m);
    MONTO_STB = 1; MONTO = m;
    tick(1);
    MONTO_STB = 0;
    tick(3);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO,
         ADVERTENCIA, BLOQUEO} !== 70'd0) begin
      errors++;
      $display("FAIL reset_outputs got bal=%0d flags=%b want all zero", BALANCE,
               {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO,
                ADVERTENCIA, BLOQUEO});
    end
    tick(2);
    rst = 1;
    tick(2);
  endtask

  task automatic test_withdrawal();
    logic [63:0] exp_bal;
    logic [39:0] exp_p;
    PIN = 16'h1194;
    insert_card(1, 64'd20000);
    enter_pin(16'h1194);
    clear_counts();
    enter_amount(32'd5000);
    exp_bal = ref_tx(1, 64'd20000, 32'd5000, exp_p);
    checks++;
    if (BALANCE !== exp_bal || BALANCE !== 64'd15000) begin
      errors++; $display("FAIL withdraw_balance got %0d want %0d", BALANCE, exp_bal);
    end
    checks++;
    if (cnt_vec() !== exp_p) begin
      errors++; $display("FAIL withdraw_pulses got %h want %h", cnt_vec(), exp_p);
    end
  endtask

  task automatic test_deposit();
    logic [63:0] exp_bal;
    logic [39:0] exp_p;
    insert_card(0, 64'd20000);
    enter_pin(16'h1194);
    clear_counts();
    enter_amount(32'd300);
    exp_bal = ref_tx(0, 64'd20000, 32'd300, exp_p);
    checks++;
    if (BALANCE !== 64'd20300) begin
      errors++; $display("FAIL deposit_balance got %0d want %0d", BALANCE, exp_bal);
    end
    checks++;
    if (cnt_vec() !== exp_p) begin
      errors++; $display("FAIL deposit_pulses got %h want %h", cnt_vec(), exp_p);
    end
    // Saturation at the top of the balance range.
    insert_card(0, 64'hFFFF_FFFF_FFFF_F000);
    enter_pin(16'h1194);
    enter_amount(32'hFFFF_FFFF);
    checks++;
    if (BALANCE !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL deposit_saturate got %h want ffffffffffffffff", BALANCE);
    end
  endtask

  task automatic test_insufficient();
    logic [63:0] exp_bal;
    logic [39:0] exp_p;
    logic [31:0] montos [2] = '{32'd20001, 32'd20000};
    foreach (montos[k]) begin
      insert_card(1, 64'd20000);
      enter_pin(16'h1194);
      clear_counts();
      enter_amount(montos[k]);
      exp_bal = ref_tx(1, 64'd20000, montos[k], exp_p);
      checks++;
      if (BALANCE !== exp_bal) begin
        errors++; $display("FAIL insuff_balance_%0d got %0d want %0d", k, BALANCE, exp_bal);
      end
      checks++;
      if (cnt_vec() !== exp_p) begin
        errors++; $display("FAIL insuff_pulses_%0d got %h want %h", k, cnt_vec(), exp_p);
      end
    end
  endtask

  task automatic test_wrong_pin();
    insert_card(1, 64'd20000);
    clear_counts();
    enter_pin(16'h1195);
    checks++;
    if ({n_pin, n_adv, 31'd0, BLOQUEO} !== {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL wrong1 got pin=%0d adv=%0d lock=%b want 1 0 0", n_pin, n_adv, BLOQUEO);
    end
    clear_counts();
    enter_pin(16'h1195);
    checks++;
    if ({n_pin, n_adv, 31'd0, BLOQUEO} !== {32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL wrong2 got pin=%0d adv=%0d lock=%b want 1 1 0", n_pin, n_adv, BLOQUEO);
    end
    clear_counts();
    enter_pin(16'h1194);
    enter_amount(32'd100);
    checks++;
    if (BALANCE !== 64'd19900 || n_pin !== 0 || n_act !== 1) begin
      errors++; $display("FAIL wrong_then_ok got bal=%0d pin=%0d act=%0d want 19900 0 1",
                         BALANCE, n_pin, n_act);
    end
  endtask

  task automatic test_lockout();
    insert_card(1, 64'd20000);
    enter_pin(16'h1195);
    enter_pin(16'h119A);
    clear_counts();
    enter_pin(16'h0000);
    checks++;
    if (BLOQUEO !== 1'b1 || n_pin !== 0 || n_adv !== 0) begin
      errors++; $display("FAIL lock_enter got lock=%b pin=%0d adv=%0d want 1 0 0",
                         BLOQUEO, n_pin, n_adv);
    end
    clear_counts();
    insert_card(0, 64'd999);
    enter_pin(16'h1194);
    enter_amount(32'd50);
    checks++;
    if (BLOQUEO !== 1'b1 || BALANCE !== 64'd20000 || cnt_vec() !== 40'd0) begin
      errors++; $display("FAIL lock_sticky got lock=%b bal=%0d pulses=%h want 1 20000 0",
                         BLOQUEO, BALANCE, cnt_vec());
    end
    #2 rst = 0;
    #1;
    checks++;
    if (BLOQUEO !== 1'b0 || BALANCE !== 64'd0) begin
      errors++; $display("FAIL lock_reset got lock=%b bal=%0d want 0 0", BLOQUEO, BALANCE);
    end
    tick(1);
    rst = 1;
    tick(1);
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp_bal;
    logic [39:0] exp_p;
    insert_card(1, 64'd20000);
    enter_digit(4'd1);
    enter_digit(4'd1);
    #2 rst = 0;
    #1;
    checks++;
    if (BALANCE !== 64'd0) begin
      errors++; $display("FAIL mid_reset_bal got %0d want 0", BALANCE);
    end
    tick(1);
    rst = 1;
    tick(1);
    clear_counts();
    insert_card(1, 64'd20000);
    enter_pin(16'h1194);
    enter_amount(32'd6000);
    exp_bal = ref_tx(1, 64'd20000, 32'd6000, exp_p);
    checks++;
    if (BALANCE !== exp_bal || cnt_vec() !== exp_p) begin
      errors++; $display("FAIL mid_reset_session got bal=%0d pulses=%h want %0d %h",
                         BALANCE, cnt_vec(), exp_bal, exp_p);
    end
  endtask

  task automatic test_ignored_strobes();
    insert_card(1, 64'd20000);
    clear_counts();
    // Digit and amount strobe together while capturing: only the digit counts.
    DIGITO_STB = 1; DIGITO = 4'd1; MONTO_STB = 1; MONTO = 32'd1;
    tick(1);
    DIGITO_STB = 0; MONTO_STB = 0;
    insert_card(0, 64'd5);
    enter_digit(4'd1);
    enter_digit(4'd9);
    enter_digit(4'd4);
    tick(3);
    enter_digit(4'd7);
    DIGITO_STB = 1; DIGITO = 4'd3; MONTO_STB = 1; MONTO = 32'd700;
    tick(1);
    DIGITO_STB = 0; MONTO_STB = 0;
    tick(3);
    checks++;
    if (BALANCE !== 64'd19300 || cnt_vec() !== {8'd1, 8'd1, 8'd0, 8'd0, 8'd0}) begin
      errors++; $display("FAIL ignored_strobes got bal=%0d pulses=%h want 19300 0101000000",
                         BALANCE, cnt_vec());
    end
  endtask

  task automatic test_random();
    logic [63:0] bal, exp_bal;
    logic [39:0] exp_p;
    logic [31:0] m;
    logic [15:0] pin, wrong;
    bit tipo;
    int nw;
    for (int s = 0; s < 40; s++) begin
      for (int d = 0; d < 4; d++) pin[d*4 +: 4] = 4'($urandom_range(0, 9));
      PIN  = pin;
      tipo = 1'($urandom_range(0, 1));
      bal  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 40000));
      m    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 30000));
      nw   = $urandom_range(0, 2);
      insert_card(tipo, bal);
      for (int w = 0; w < nw; w++) begin
        wrong = pin ^ (16'd1 << $urandom_range(0, 15));
        clear_counts();
        enter_pin(wrong);
        checks++;
        if (n_pin !== 1 || n_adv !== (w == 1 ? 1 : 0)) begin
          errors++; $display("FAIL rnd%0d_wrong%0d got pin=%0d adv=%0d want 1 %0d",
                             s, w, n_pin, n_adv, (w == 1));
        end
      end
      enter_pin(pin);
      clear_counts();
      enter_amount(m);
      exp_bal = ref_tx(tipo, bal, m, exp_p);
      checks++;
      if (BALANCE !== exp_bal || cnt_vec() !== exp_p) begin
        errors++; $display("FAIL rnd%0d_tx got bal=%h pulses=%h want %h %h",
                           s, BALANCE, cnt_vec(), exp_bal, exp_p);
      end
    end
  endtask

  task automatic test_pulse_width();
    checks++;
    if (n_doble !== 0 || n_adv_solo !== 0) begin
      errors++; $display("FAIL pulse_width got long=%0d lone_adv=%0d want 0 0", n_doble, n_adv_solo);
    end
  endtask

  initial begin
    test_reset();
    test_withdrawal();
    test_deposit();
    test_insufficient();
    test_wrong_pin();
    test_lockout();
    test_reset_mid();
    test_ignored_strobes();
    test_random();
    test_pulse_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
